router_fifo: RTL and testbench
==============================

// Module: router_fifo
// PURPOSE
//  Per-port output FIFO of the 1x3 router. Sits directly downstream of the
//  router synchronizer: it takes one write-enable bit and one soft-reset line
//  from the synchronizer, and it returns full/empty status to it.
//  It buffers packet bytes together with a header-marker bit. It tracks the
//  payload length so that data_out floats once the packet has been drained.
// PARAMETERS
//  WIDTH  8   data byte width (header byte: [7:2]=payload length, [1:0]=addr)
//  DEPTH  16  number of entries; must be a power of 2
//  AW     4   log2(DEPTH); pointers are AW+1 bits wide (extra wrap bit)
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  soft_reset  in   1      synchronous flush from the synchronizer (timeout)
//  write_enb   in   1      write request (one bit of the synchronizer's wr_enb)
//  read_enb    in   1      read request from the destination port
//  lfd_state   in   1      1 = data_in is the header byte (load-first-data)
//  data_in     in   WIDTH  byte to store
//  data_out    out  WIDTH  registered read data; 'z when idle after a packet
//  full        out  1      FIFO holds DEPTH entries
//  empty       out  1      FIFO holds 0 entries
//  ovf_err     out  1      sticky overflow/underflow flag (ROUTER_FIFO_ERR_EN only)
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-high.
//  Storage: DEPTH x (WIDTH+1). Bit [WIDTH] holds lfd_state, captured at write.
//  Pointers: wr_ptr and rd_ptr are (AW+1) bits and wrap naturally.
//   - empty = (wr_ptr == rd_ptr).
//   - full  = MSBs differ and the low AW bits are equal.
//   - Both flags are combinational from the pointers.
//  Write: when write_enb && !full, store mem[wr_ptr[AW-1:0]] <= {lfd_state,data_in}
//   and increment wr_ptr.
//  Read: when read_enb && !empty, data_out <= mem[rd][WIDTH-1:0] and increment
//   rd_ptr. Latency is 1 clock: the byte appears after the edge that samples read_enb.
//  Packet counter pkt_cnt (7 bits):
//   - On a read of an entry with bit[WIDTH]=1, load pkt_cnt <= data[7:2] + 1
//     (payload plus parity).
//   - On a read of a non-header entry with pkt_cnt != 0, decrement pkt_cnt.
//   - pkt_cnt never underflows below 0.
//  Float: on any edge with no valid read and pkt_cnt == 0, data_out <= 'z.
//  Simultaneous read and write:
//   - Neither full nor empty: both occur in the same cycle; occupancy is unchanged.
//   - Full: the read occurs and the write is dropped, because full is evaluated
//     before the edge.
//   - Empty: the write occurs and the read is ignored; data_out holds.
//  Overflow (write while full) and underflow (read while empty):
//   - The request is ignored.
//   - Pointers, memory and pkt_cnt are unchanged.
//  rst (async):
//   - wr_ptr, rd_ptr and pkt_cnt go to 0 and data_out goes to 0.
//   - Result: empty=1, full=0.
//   - All memory entries are cleared to 0.
//  soft_reset (sync, takes priority over read and write in the same cycle):
//   - wr_ptr, rd_ptr and pkt_cnt go to 0 and data_out goes to 'z.
//   - Memory is cleared.
//   - Applies mid-packet too: the rest of the packet is discarded.
// CONFIGURATION
//  ROUTER_FIFO_ERR_EN defined:
//   - ovf_err sets to 1 on a write with full=1 or a read with empty=1.
//   - It stays set until rst or soft_reset.
//   - Reset value is 0.
//  ROUTER_FIFO_ERR_EN undefined:
//   - The ovf_err port and its logic are absent.
//   - All other behaviour is identical.
// TESTING
//  1. rst=1 then 0 -> empty=1, full=0, data_out=8'h00.
//  2. Write header 8'h0C with lfd=1, then 8'hA1, 8'hA2, 8'hA3, then parity 8'h5F.
//     Read 5 times. Expected: data_out sequence 0C,A1,A2,A3,5F; pkt_cnt reaches 0;
//     on the next idle cycle data_out='z; then empty=1.
//  3. 16 back-to-back writes -> full=1 after the 16th. A 17th write of 8'hFF is
//     dropped. 16 reads return the original data; ovf_err=1 when the macro is on.
//  4. When full, assert read_enb and write_enb together -> the read returns the
//     oldest byte, the write is dropped, full=0 afterwards.
//  5. Write 20 and read 20 interleaved (crossing the pointer wrap) -> data stays
//     in order, and full/empty are correct at the wrap boundary.
//  6. soft_reset after 2 reads of a 4-byte packet -> the next cycle gives empty=1,
//     full=0, data_out='z; ovf_err cleared.

Source files
------------

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: buffers packet bytes with a header marker
// and floats data_out once a packet has drained. Optional macro: ROUTER_FIFO_ERR_EN (sticky ovf_err).
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
`ifdef ROUTER_FIFO_ERR_EN
  ,
  output logic             ovf_err
`endif
);

  localparam logic [AW:0] PtrOne = 1;

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [6:0]       pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             oe_q, oe_d;
  logic             do_write, do_read;
  logic [WIDTH:0]   rd_word;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_write = write_enb && !full;
    do_read  = read_enb && !empty;
    rd_word  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next-state for pointers, packet counter and the output register/enable
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    data_d    = data_q;
    oe_d      = oe_q;
    if (soft_reset) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      pkt_cnt_d = '0;
      data_d    = '0;
      oe_d      = 1'b0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_read) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
        data_d   = rd_word[WIDTH-1:0];
        oe_d     = 1'b1;
        if (rd_word[WIDTH])
          pkt_cnt_d = {1'b0, rd_word[7:2]} + 7'd1;
        else if (pkt_cnt_q != 7'd0)
          pkt_cnt_d = pkt_cnt_q - 7'd1;
      end else if (pkt_cnt_q == 7'd0) begin
        oe_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      data_q    <= '0;
      oe_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
    end
  end

  // Storage is wiped by both resets so stale headers can never be re-read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (soft_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_write) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  assign data_out = oe_q ? data_q : {WIDTH{1'bz}};

`ifdef ROUTER_FIFO_ERR_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (soft_reset)
      ovf_d = 1'b0;
    else if ((write_enb && full) || (read_enb && empty))
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: a queue model predicts data_out every cycle,
// a negedge monitor compares; flags are checked right after each edge.
module tb_router_fifo;

  logic       clk = 1'b0;
  logic       rst, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in;
  wire  [7:0] data_out;
  logic       full, empty;
`ifdef ROUTER_FIFO_ERR_EN
  logic       ovf_err;
`endif

  router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .soft_reset(soft_reset), .write_enb(write_enb),
    .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty)
`ifdef ROUTER_FIFO_ERR_EN
    , .ovf_err(ovf_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       flt;
    logic [7:0] val;
  } exp_t;

  exp_t       expQ[$];
  logic [8:0] modelQ[$];
  logic [6:0] mCnt;
  logic       mFlt;
  logic [7:0] mOut;
  logic       mErr;

  // Monitor: one expected data_out value per clock edge
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      total++;
      if (e.flt) begin
        if (!(data_out === 8'hzz)) begin
          bad++;
          $display("[TB] FAIL data_out_float actual=%h required=zz", data_out);
        end
      end else if (data_out !== e.val) begin
        bad++;
        $display("[TB] FAIL data_out actual=%h required=%h", data_out, e.val);
      end
    end
  end

  task checkBit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task checkOutput();
    checkBit("empty", empty, modelQ.size() == 0);
    checkBit("full", full, modelQ.size() == 16);
`ifdef ROUTER_FIFO_ERR_EN
    checkBit("ovf_err", ovf_err, mErr);
`endif
  endtask

  task applyStimulus(input logic we, input logic re, input logic lfd,
                     input logic sr, input logic [7:0] din);
    logic mFull, mEmpty;
    logic [8:0] ent;
    exp_t e;
    @(negedge clk);
    write_enb = we; read_enb = re; lfd_state = lfd; soft_reset = sr; data_in = din;
    @(posedge clk);
    if (sr) begin
      modelQ.delete();
      mCnt = 0; mFlt = 1'b1; mErr = 1'b0;
    end else begin
      mFull  = (modelQ.size() == 16);
      mEmpty = (modelQ.size() == 0);
      if ((we && mFull) || (re && mEmpty)) mErr = 1'b1;
      if (re && !mEmpty) begin
        ent  = modelQ.pop_front();
        mOut = ent[7:0];
        mFlt = 1'b0;
        if (ent[8]) mCnt = {1'b0, ent[7:2]} + 7'd1;
        else if (mCnt != 0) mCnt = mCnt - 7'd1;
      end else if (mCnt == 0) begin
        mFlt = 1'b1;
      end
      if (we && !mFull) modelQ.push_back({lfd, din});
    end
    e.flt = mFlt;
    e.val = mOut;
    expQ.push_back(e);
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; soft_reset = 0; write_enb = 0; read_enb = 0; lfd_state = 0; data_in = 0;
    mCnt = 0; mFlt = 0; mOut = 8'h00; mErr = 0;

    // Reset state, both during reset and just after release
    repeat (2) @(negedge clk);
    checkBit("rst_data_nonzero", data_out !== 8'h00, 1'b0);
    checkOutput();
    rst = 1'b0;
    #1;
    checkBit("rel_data_nonzero", data_out !== 8'h00, 1'b0);
    checkOutput();

    // Packet: header 0C (payload 3) + 3 bytes + parity, then drain and float
    applyStimulus(1, 0, 1, 0, 8'h0C);
    applyStimulus(1, 0, 0, 0, 8'hA1);
    applyStimulus(1, 0, 0, 0, 8'hA2);
    applyStimulus(1, 0, 0, 0, 8'hA3);
    applyStimulus(1, 0, 0, 0, 8'h5F);
    repeat (5) applyStimulus(0, 1, 0, 0, 8'h00);
    repeat (2) applyStimulus(0, 0, 0, 0, 8'h00);

    // Fill, overflow write, drain
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 0, 8'h10 + 8'(i));
    applyStimulus(1, 0, 0, 0, 8'hFF);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);

    // Simultaneous read/write while full drops the write; then underflow read
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 0, 8'h40 + 8'(i));
    applyStimulus(1, 1, 0, 0, 8'hEE);
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 0, 8'h00);

    // Interleaved traffic crossing the pointer wrap
    for (int i = 0; i < 20; i++) applyStimulus(1, i >= 4, 0, 0, 8'h80 + 8'(i));
    repeat (4) applyStimulus(0, 1, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'h00);

    // Soft reset mid-packet (header 08 = payload 2), with competing read/write
    applyStimulus(1, 0, 1, 0, 8'h08);
    applyStimulus(1, 0, 0, 0, 8'hB1);
    applyStimulus(1, 0, 0, 0, 8'hB2);
    applyStimulus(1, 0, 0, 0, 8'hC3);
    repeat (2) applyStimulus(0, 1, 0, 0, 8'h00);
    applyStimulus(1, 1, 0, 1, 8'h77);
    applyStimulus(0, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 0, 8'h00);

    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
